partial_sum_engine: RTL and testbench

Parametrised successor to the single-bit partial-sum calculator for the successive-cancellation polar decoder. Accepts decoded bits u_i in natural order and folds them up the decoding tree, XOR-merging completed right children with their stored left siblings. Keeps each depth's left-sibling partial-sum vector available for the g-function datapath. Supports code length N = 2^LOG_N and processes P bits per cycle; it also emits the re-encoded codeword x at the end of each frame.

---
 rtl/polar_ps_pkg.sv | 24 ++
 rtl/merge_depth_calc.sv | 31 +++
 rtl/partial_sum_engine.sv | 171 +++++++++++++++++
 tb/tb_partial_sum_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_ps_pkg.sv
// Shared types and helpers for the polar decoder partial-sum engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package polar_ps_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        STORE = 2'd2
    } ps_state_t;

    // Width needed to hold a depth or trailing-ones count in 0..log_n.
    function automatic int depth_width(input int log_n);
        return $clog2(log_n + 1);
    endfunction

    // Depth d region is 2^(log_n-d) bits long and starts at S index equal to
    // its own length, so the tree packs into S[1..2N-1] without gaps.
    function automatic int unsigned region_base(input int unsigned depth,
                                                input int unsigned log_n);
        return 32'd1 << (log_n - depth);
    endfunction

endpackage

// File: rtl/merge_depth_calc.sv
// Trailing-ones count of a bit index: how many tree levels a new bit completes.
// Latency: combinational.
// Backpressure: none.
// Ports: idx = decoded-bit index, ones = number of consecutive 1s from bit 0.
module merge_depth_calc
    import polar_ps_pkg::*;
#(
    parameter int LOG_N = 10
) (
    input  logic [LOG_N-1:0]              idx,
    output logic [depth_width(LOG_N)-1:0] ones
);
    localparam int DW = depth_width(LOG_N);

    logic stop;

    always_comb begin
        ones = '0;
        stop = 1'b0;
        for (int b = 0; b < LOG_N; b++) begin
            if (!stop) begin
                if (idx[b]) begin
                    ones = DW'(b + 1);
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/partial_sum_engine.sv
// Partial-sum engine for an SC polar decoder: folds decoded bits up the tree, P bits/cycle.
// Latency: accept at c -> update_done at c+1+sum_k ceil(2^k/P)+ceil(2^t/P) (min c+2).
// Backpressure: bit_ready only in IDLE; bit_valid while busy is ignored, caller holds the bit.
// Ports: start/bit_valid/bit_value in; bit_ready/update_done/codeword_done/busy out;
//        rd_depth/rd_offset select P bits of a stored region on rd_data (combinational).
module partial_sum_engine
    import polar_ps_pkg::*;
#(
    parameter int LOG_N = 10,
    parameter int P     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          bit_valid,
    input  logic                          bit_value,
    output logic                          bit_ready,
    output logic                          update_done,
    output logic                          codeword_done,
    output logic                          busy,
    input  logic [depth_width(LOG_N)-1:0] rd_depth,
    input  logic [LOG_N-1:0]              rd_offset,
    output logic [P-1:0]                  rd_data
);
    localparam int N       = 1 << LOG_N;
    localparam int DEPTH_W = depth_width(LOG_N);

    ps_state_t            state, state_n;
    logic [LOG_N-1:0]     idx;        // index of the next bit to accept
    logic [LOG_N-1:0]     j_q;        // chunk offset within the current run
    logic [DEPTH_W-1:0]   t_q;        // trailing ones of the accepted index
    logic [DEPTH_W-1:0]   k_q;        // current merge level
    logic [DEPTH_W-1:0]   ones;
    logic                 last_q;     // accepted bit is u_{N-1}
    logic [2*N-1:0]       s;
    logic [N-1:0]         w;
    logic                 accept;
    logic                 chunk_last;
    logic [LOG_N:0]       run_len;    // L = 2^k in MERGE, M = 2^t in STORE
    logic [LOG_N-1:0]     lane_pos [P];
    logic [LOG_N:0]       s_idx    [P];
    logic [P-1:0]         lane_on;
    logic [LOG_N:0]       rd_len;
    logic [LOG_N:0]       rd_pos;

    merge_depth_calc #(.LOG_N(LOG_N)) u_depth (
        .idx  (idx),
        .ones (ones)
    );

    // Merge level k reads the depth LOG_N-k buffer; STORE writes depth LOG_N-t.
    // In both cases the region base equals the run length, so one index
    // (run_len + lane position) addresses both S and the upper half of W.
    always_comb begin
        run_len    = (LOG_N+1)'(region_base(LOG_N - int'((state == STORE) ? t_q : k_q), LOG_N));
        chunk_last = ({1'b0, j_q} + (LOG_N+1)'(P)) >= run_len;
        for (int b = 0; b < P; b++) begin
            lane_pos[b] = j_q + LOG_N'(b);
            s_idx[b]    = run_len + {1'b0, lane_pos[b]};
            // Runs shorter than P use only the low lanes.
            lane_on[b]  = (LOG_N+1)'(b) < run_len;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_ready = (state == IDLE);
        busy      = (state != IDLE);
        accept    = bit_valid && (state == IDLE) && !start;
        case (state)
            IDLE:    if (accept) state_n = (ones != '0) ? MERGE : STORE;
            MERGE:   if (chunk_last && (k_q == t_q - DEPTH_W'(1))) state_n = STORE;
            STORE:   if (chunk_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            idx           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            t_q           <= '0;
            last_q        <= 1'b0;
            update_done   <= 1'b0;
            codeword_done <= 1'b0;
        end else begin
            update_done   <= 1'b0;
            codeword_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        t_q    <= ones;
                        last_q <= &idx;
                        k_q    <= '0;
                        j_q    <= '0;
                    end
                end
                MERGE: begin
                    if (chunk_last) begin
                        j_q <= '0;
                        k_q <= k_q + DEPTH_W'(1);
                    end else begin
                        j_q <= j_q + LOG_N'(P);
                    end
                end
                STORE: begin
                    if (chunk_last) begin
                        j_q           <= '0;
                        idx           <= idx + LOG_N'(1);
                        update_done   <= 1'b1;
                        codeword_done <= last_q;
                    end else begin
                        j_q <= j_q + LOG_N'(P);
                    end
                end
                default: ;
            endcase
        end
    end

    // W needs no clearing on start: every W[1..L-1] read by merge k was
    // rewritten earlier in the same update, and W[0] is loaded on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            s <= '0;
            w <= '0;
        end else if (!start) begin
            if (accept) begin
                w[0] <= bit_value;
            end
            for (int b = 0; b < P; b++) begin
                if (lane_on[b]) begin
                    if (state == MERGE) begin
                        w[s_idx[b][LOG_N-1:0]] <= w[lane_pos[b]];
                        w[lane_pos[b]]         <= s[s_idx[b]] ^ w[lane_pos[b]];
                    end else if (state == STORE) begin
                        s[s_idx[b]] <= w[lane_pos[b]];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_len  = '0;
        rd_pos  = '0;
        if (int'(rd_depth) <= LOG_N) begin
            rd_len = (LOG_N+1)'(region_base(int'(rd_depth), LOG_N));
        end
        for (int b = 0; b < P; b++) begin
            rd_pos = {1'b0, rd_offset} + (LOG_N+1)'(b);
            if (rd_pos < rd_len) begin
                rd_data[b] = s[rd_len + rd_pos];
            end
        end
    end

endmodule

// File: tb/tb_partial_sum_engine.sv
// Randomized and directed check of partial_sum_engine against a polar-encoder model.
// Instances: 0 = (LOG_N 3, P 2), 1 = (LOG_N 3, P 1), 2 = (LOG_N 10, P 4).
// Regions are compared with x_j = XOR of u_i over all i whose bits cover j.
module tb_partial_sum_engine;
    localparam int NI     = 3;
    localparam int FRAMES = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_v       [NI];
    logic       bit_valid_v   [NI];
    logic       bit_value_v   [NI];
    logic       bit_ready_v   [NI];
    logic       update_done_v [NI];
    logic       codeword_done_v [NI];
    logic       busy_v        [NI];
    logic [3:0] rd_depth_v    [NI];
    logic [9:0] rd_offset_v   [NI];
    logic [1:0] rd_data0;
    logic [0:0] rd_data1;
    logic [3:0] rd_data2;

    int n_checks = 0;
    int n_fails  = 0;
    bit u_m     [NI][1024];
    int bit_cnt [NI];

    partial_sum_engine #(.LOG_N(3), .P(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .bit_valid(bit_valid_v[0]),
        .bit_value(bit_value_v[0]), .bit_ready(bit_ready_v[0]), .update_done(update_done_v[0]),
        .codeword_done(codeword_done_v[0]), .busy(busy_v[0]),
        .rd_depth(rd_depth_v[0][1:0]), .rd_offset(rd_offset_v[0][2:0]), .rd_data(rd_data0)
    );

    partial_sum_engine #(.LOG_N(3), .P(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .bit_valid(bit_valid_v[1]),
        .bit_value(bit_value_v[1]), .bit_ready(bit_ready_v[1]), .update_done(update_done_v[1]),
        .codeword_done(codeword_done_v[1]), .busy(busy_v[1]),
        .rd_depth(rd_depth_v[1][1:0]), .rd_offset(rd_offset_v[1][2:0]), .rd_data(rd_data1)
    );

    partial_sum_engine #(.LOG_N(10), .P(4)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .bit_valid(bit_valid_v[2]),
        .bit_value(bit_value_v[2]), .bit_ready(bit_ready_v[2]), .update_done(update_done_v[2]),
        .codeword_done(codeword_done_v[2]), .busy(busy_v[2]),
        .rd_depth(rd_depth_v[2]), .rd_offset(rd_offset_v[2]), .rd_data(rd_data2)
    );

    function automatic int lg(input int sel);
        return (sel == 2) ? 10 : 3;
    endfunction

    function automatic int pp(input int sel);
        case (sel)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic [3:0] rd_data_of(input int sel);
        case (sel)
            0:       return {2'b00, rd_data0};
            1:       return {3'b000, rd_data1};
            default: return rd_data2;
        endcase
    endfunction

    // Bit j of the m-point polar transform of u[base .. base+m-1].
    function automatic bit enc_bit(input int sel, input int base, input int m, input int j);
        bit r = 1'b0;
        for (int a = 0; a < m; a++) begin
            if ((a & j) == j) r ^= u_m[sel][base + a];
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reads a whole region P bits at a time; zero selects an all-zero expectation.
    task automatic check_region(input int sel, input int depth, input int base,
                                input int m, input bit zero, input string tag);
        logic [1023:0] got;
        logic [1023:0] exp;
        logic [3:0]    rd;
        int            p;
        int            span;
        p    = pp(sel);
        got  = '0;
        exp  = '0;
        if (!zero) begin
            for (int j = 0; j < m; j++) exp[j] = enc_bit(sel, base, m, j);
        end
        span = (m > p) ? m : p;
        rd_depth_v[sel] = 4'(depth);
        for (int off = 0; off < m; off += p) begin
            rd_offset_v[sel] = 10'(off);
            #1;
            rd = rd_data_of(sel);
            for (int b = 0; b < p; b++) got[off + b] = rd[b];
        end
        for (int wd = 0; wd * 64 < span; wd++) begin
            check_eq($sformatf("%s_w%0d", tag, wd), got[wd*64 +: 64], exp[wd*64 +: 64]);
        end
    endtask

    // Offers one bit and counts cycles from the accept edge to update_done.
    task automatic send_bit(input int sel, input bit val, input bit hold, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (bit_ready_v[sel] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bit_valid_v[sel] = 1'b1;
        bit_value_v[sel] = val;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check_eq($sformatf("busy_after_accept%0d", sel), busy_v[sel], 1);
                check_eq($sformatf("ready_after_accept%0d", sel), bit_ready_v[sel], 0);
                if (!hold) bit_valid_v[sel] = 1'b0;
            end
        end while (update_done_v[sel] !== 1'b1 && lat < 3000);
        bit_valid_v[sel] = 1'b0;
    endtask

    task automatic do_bit(input int sel, input bit val, input bit hold);
        int n;
        int i;
        int t;
        int m;
        int exp_lat;
        int lat;
        n = 1 << lg(sel);
        i = bit_cnt[sel];
        u_m[sel][i] = val;
        t = 0;
        while (t < lg(sel) && ((i >> t) & 1) == 1) t++;
        exp_lat = 1 + cdiv(1 << t, pp(sel));
        for (int k = 0; k < t; k++) exp_lat += cdiv(1 << k, pp(sel));
        send_bit(sel, val, hold, lat);
        check_eq($sformatf("lat%0d_bit%0d", sel, i), 64'(lat), 64'(exp_lat));
        check_eq($sformatf("cwdone%0d_bit%0d", sel, i), codeword_done_v[sel], (i == n - 1));
        m = 1 << t;
        check_region(sel, lg(sel) - t, i - m + 1, m, 1'b0,
                     $sformatf("region%0d_bit%0d_d%0d", sel, i, lg(sel) - t));
        bit_cnt[sel] = (i + 1) % n;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int lat;
        reset = 1'b1;
        for (int s = 0; s < NI; s++) begin
            start_v[s]     = 1'b0;
            bit_valid_v[s] = 1'b0;
            bit_value_v[s] = 1'b0;
            rd_depth_v[s]  = '0;
            rd_offset_v[s] = '0;
            bit_cnt[s]     = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < NI; s++) begin
            check_eq($sformatf("rst_ready%0d", s), bit_ready_v[s], 1);
            check_eq($sformatf("rst_busy%0d", s), busy_v[s], 0);
            check_eq($sformatf("rst_done%0d", s), update_done_v[s], 0);
            check_eq($sformatf("rst_cw%0d", s), codeword_done_v[s], 0);
        end
        check_region(0, 0, 0, 8, 1'b1, "rst_root0");

        // Single leading one: x = 1,0,...,0.
        for (int i = 0; i < 8; i++) do_bit(0, (i == 0), 1'b0);
        // All ones: depth-1 region 0001 after bit 3, root 0..01, bit 7 at c+9.
        for (int i = 0; i < 8; i++) do_bit(0, 1'b1, 1'b0);
        // P = 1, only u_7 set: root all ones, bit 7 at c+16.
        for (int i = 0; i < 8; i++) do_bit(1, (i == 7), 1'b0);

        // Abort during MERGE of bit 3.
        for (int i = 0; i < 3; i++) do_bit(0, 1'($urandom_range(0, 1)), 1'b0);
        @(negedge clk);
        bit_valid_v[0] = 1'b1;
        bit_value_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_in_merge", busy_v[0], 1);
        bit_valid_v[0] = 1'b0;
        start_v[0]     = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check_eq("abort_ready", bit_ready_v[0], 1);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (update_done_v[0] === 1'b1) cnt++;
        end
        check_eq("abort_no_done", 64'(cnt), 0);
        bit_cnt[0] = 0;

        // start together with bit_valid: start wins.
        start_v[0]     = 1'b1;
        bit_valid_v[0] = 1'b1;
        bit_value_v[0] = 1'b1;
        @(negedge clk);
        start_v[0]     = 1'b0;
        bit_valid_v[0] = 1'b0;
        check_eq("start_wins", busy_v[0], 0);

        // Restarted frame; bit 2 keeps bit_valid high while busy.
        do_bit(0, 1'b1, 1'b0);
        do_bit(0, 1'b0, 1'b0);
        do_bit(0, 1'b1, 1'b1);
        do_bit(0, 1'b1, 1'b0);

        // Reset during STORE of bit 3 on the P = 1 instance.
        for (int i = 0; i < 3; i++) do_bit(1, 1'b1, 1'b0);
        @(negedge clk);
        bit_valid_v[1] = 1'b1;
        bit_value_v[1] = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        bit_valid_v[1] = 1'b0;
        check_eq("store_busy", busy_v[1], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_mid_ready", bit_ready_v[1], 1);
        check_eq("rst_mid_busy", busy_v[1], 0);
        for (int d = 0; d <= 3; d++) begin
            check_region(1, d, 0, 1 << (3 - d), 1'b1, $sformatf("rst_mid_zero_d%0d", d));
        end
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (update_done_v[1] === 1'b1) cnt++;
        end
        check_eq("rst_mid_no_done", 64'(cnt), 0);
        for (int s = 0; s < NI; s++) bit_cnt[s] = 0;

        // Random frames on the full-size instance.
        for (int f = 0; f < FRAMES; f++) begin
            for (int i = 0; i < 1024; i++) do_bit(2, 1'($urandom_range(0, 1)), 1'b0);
        end

        lat = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
